// File: rtl/frame_pkg.sv
// Shared constants, FSM encoding and FIFO entry type for the frame collector.
package frame_pkg;

    localparam int MAX_LEN = 15;
    localparam int LEN_W   = 4;
    localparam int PORT_W  = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    typedef struct packed {
        logic [PORT_W-1:0]  port;
        logic [MAX_LEN-1:0] data;
        logic [LEN_W-1:0]   len;
        logic               err;
    } entry_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/frame_fifo.sv
// Two-entry synchronous FIFO of completed frames; a push into a full FIFO is
// accepted only when a pop happens on the same cycle.
module frame_fifo
    import frame_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t entry,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty,
    output logic   accepted
);

    entry_t     mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       do_pop;
    logic       do_push;

    assign empty    = (count == 2'd0);
    assign full     = (count == 2'd2);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign accepted = do_push;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage is reset on purpose: the head entry drives the
            // out_* ports directly, and those must read zero out of reset.
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/frame_collector.sv
// Reassembles serial payload bits into tagged parallel frames behind a 2-deep
// valid/ready queue. Define FRAME_STATS_EN to add per-port frame and drop counters.
module frame_collector
    import frame_pkg::*;
#(
    parameter int MAX_LEN = frame_pkg::MAX_LEN,
    parameter int LEN_W   = frame_pkg::LEN_W,
    parameter int PORT_W  = frame_pkg::PORT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic               ser_bit,
    input  logic               ser_valid,
    input  logic [PORT_W-1:0]  port_addr,
    input  logic [LEN_W-1:0]   data_len,
    input  logic               frame_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PORT_W-1:0]  out_port,
    output logic [MAX_LEN-1:0] out_data,
    output logic [LEN_W-1:0]   out_len,
    output logic               out_err,
    output logic               drop
`ifdef FRAME_STATS_EN
    ,
    output logic [(1<<PORT_W)*8-1:0] stat_frames,
    output logic [7:0]               stat_drops
`endif
);

    state_t             state, state_n;
    logic [PORT_W-1:0]  port_q, port_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic [MAX_LEN-1:0] shreg, shreg_n;
    logic [LEN_W-1:0]   cnt, cnt_n;
    logic               ovf, ovf_n;
    logic               commit;
    entry_t             commit_entry;
    entry_t             head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               accepted;
    logic               pop;
    logic               drop_q;

    // A bit arriving with frame_done is shifted in before the commit, so the
    // committed entry is built from the already-updated shreg/cnt/ovf values.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_n      = state;
        port_n       = port_q;
        len_n        = len_q;
        shreg_n      = shreg;
        cnt_n        = cnt;
        ovf_n        = ovf;
        commit       = 1'b0;
        commit_entry = '0;

        if (clk_en) begin
            if (state == IDLE) begin
                port_n  = port_addr;
                len_n   = data_len;
                shreg_n = '0;
                cnt_n   = '0;
                ovf_n   = 1'b0;
            end

            // NOTE: blocking assignments here are deliberate: the frame_done
            // branch below must see the values the shift branch just produced.
            if (ser_valid) begin
                if (cnt_n < LEN_W'(MAX_LEN)) begin
                    shreg_n = {shreg_n[MAX_LEN-2:0], ser_bit};
                    cnt_n   = cnt_n + 1'b1;
                end else begin
                    ovf_n = 1'b1;
                end
                state_n = COLLECT;
            end

            if (frame_done) begin
                commit       = 1'b1;
                commit_entry = '{port: port_n,
                                 data: shreg_n,
                                 len:  cnt_n,
                                 err:  (cnt_n != len_n) || ovf_n};
                state_n      = IDLE;
                shreg_n      = '0;
                cnt_n        = '0;
                ovf_n        = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            port_q <= '0;
            len_q  <= '0;
            shreg  <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            state  <= state_n;
            port_q <= port_n;
            len_q  <= len_n;
            shreg  <= shreg_n;
            cnt    <= cnt_n;
            ovf    <= ovf_n;
            drop_q <= commit && !accepted;
        end
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    frame_fifo u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (commit),
        .entry    (commit_entry),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .accepted (accepted)
    );

    assign out_port = head.port;
    assign out_data = head.data;
    assign out_len  = head.len;
    assign out_err  = head.err;
    assign drop     = drop_q;

`ifdef FRAME_STATS_EN
    logic [7:0] frame_cnt [1<<PORT_W];
    logic [7:0] drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < (1 << PORT_W); p++) begin
                frame_cnt[p] <= 8'd0;
            end
            drop_cnt <= 8'd0;
        end else begin
            if (accepted) begin
                frame_cnt[commit_entry.port] <= sat_inc(frame_cnt[commit_entry.port]);
            end
            if (commit && !accepted) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    for (genvar p = 0; p < (1 << PORT_W); p++) begin : g_stat
        assign stat_frames[p*8 +: 8] = frame_cnt[p];
    end
    assign stat_drops = drop_cnt;
`endif

endmodule

// File: tb/tb_frame_collector.sv
// Self-checking bench for frame_collector: directed scenarios plus randomized
// frames, compared every cycle against a transaction-level queue model.
module tb_frame_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b0;
    logic        ser_bit = 1'b0;
    logic        ser_valid = 1'b0;
    logic [1:0]  port_addr = 2'd0;
    logic [3:0]  data_len = 4'd0;
    logic        frame_done = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [1:0]  out_port;
    logic [14:0] out_data;
    logic [3:0]  out_len;
    logic        out_err;
    logic        drop;

    frame_collector dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .ser_bit    (ser_bit),
        .ser_valid  (ser_valid),
        .port_addr  (port_addr),
        .data_len   (data_len),
        .frame_done (frame_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_port   (out_port),
        .out_data   (out_data),
        .out_len    (out_len),
        .out_err    (out_err),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int port;
        int data;
        int len;
        int err;
    } exp_t;

    exp_t q[$];
    exp_t exp_entry;
    bit   exp_commit = 1'b0;
    bit   exp_drop = 1'b0;
    bit   rand_ready = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_sz;
    bit   model_pop;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level expectation: keep the first 15 bits, flag length mismatch or overflow.
    function automatic exp_t expect_of(input int port, input int len, input int n,
                                       input logic [31:0] pat);
        exp_t        e;
        int          kept = (n > 15) ? 15 : n;
        logic [31:0] v = pat >> (n - kept);
        logic [31:0] mask = (32'h1 << kept) - 32'h1;
        e.port = port;
        e.data = int'(v & mask);
        e.len  = kept;
        e.err  = ((kept != len) || (n > 15)) ? 1 : 0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Queue model: pop first, then push the committed frame or flag a drop.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            exp_drop = 1'b0;
        end else begin
            model_sz  = q.size();
            model_pop = (model_sz != 0) && (out_ready === 1'b1);
            exp_drop  = 1'b0;
            if (model_pop) void'(q.pop_front());
            if (exp_commit) begin
                if (model_sz == 2 && !model_pop) exp_drop = 1'b1;
                else q.push_back(exp_entry);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", 32'(out_valid), (q.size() != 0) ? 1 : 0);
            if (q.size() != 0) begin
                check("out_port", 32'(out_port), q[0].port);
                check("out_data", 32'(out_data), q[0].data);
                check("out_len",  32'(out_len),  q[0].len);
                check("out_err",  32'(out_err),  q[0].err);
            end
            check("drop", 32'(drop), exp_drop ? 1 : 0);
        end
    end

    task automatic send_frame(input int port, input int len, input int n,
                              input logic [31:0] pat, input bit en_toggle,
                              input bit ready_on_done);
        port_addr = 2'(port);
        data_len  = 4'(len);
        for (int i = 0; i < n; i++) begin
            if (en_toggle) begin
                clk_en     = 1'b0;
                ser_valid  = 1'($urandom_range(0, 1));
                ser_bit    = 1'($urandom_range(0, 1));
                frame_done = 1'($urandom_range(0, 1));
                tick();
            end
            clk_en     = 1'b1;
            ser_valid  = 1'b1;
            ser_bit    = pat[n-1-i];
            frame_done = 1'b0;
            tick();
        end
        if (en_toggle) begin
            clk_en     = 1'b0;
            ser_valid  = 1'b0;
            frame_done = 1'b1;
            tick();
        end
        clk_en     = 1'b1;
        ser_valid  = 1'b0;
        frame_done = 1'b1;
        exp_entry  = expect_of(port, len, n, pat);
        exp_commit = 1'b1;
        if (ready_on_done) out_ready = 1'b1;
        tick();
        exp_commit = 1'b0;
        frame_done = 1'b0;
        if (ready_on_done) out_ready = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        exp_t pin;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_valid", 32'(out_valid), 0);
        check("reset_port",  32'(out_port),  0);
        check("reset_data",  32'(out_data),  0);
        check("reset_len",   32'(out_len),   0);
        check("reset_err",   32'(out_err),   0);
        check("reset_drop",  32'(drop),      0);

        pin = expect_of(2, 4, 4, 32'hB);
        check("model_pin_data", 32'(pin.data), 32'h000B);
        pin = expect_of(0, 15, 17, 32'h1FFFF);
        check("model_pin_ovf", 32'(pin.data), 32'h7FFF);

        // Basic frame: port 2, 1011.
        send_frame(2, 4, 4, 32'hB, 1'b0, 1'b0);
        check("t1_valid", 32'(out_valid), 1);
        check("t1_port",  32'(out_port),  2);
        check("t1_data",  32'(out_data),  32'h000B);
        check("t1_len",   32'(out_len),   4);
        check("t1_err",   32'(out_err),   0);
        pop_one();
        check("t1_popped", 32'(out_valid), 0);

        // Short frame: declared 5, received 110.
        send_frame(1, 5, 3, 32'h6, 1'b0, 1'b0);
        check("t2_data", 32'(out_data), 32'h0006);
        check("t2_len",  32'(out_len),  3);
        check("t2_err",  32'(out_err),  1);
        pop_one();

        // Three frames with no consumer: third is dropped.
        send_frame(0, 2, 2, 32'h2, 1'b0, 1'b0);
        send_frame(3, 3, 3, 32'h5, 1'b0, 1'b0);
        send_frame(2, 1, 1, 32'h1, 1'b0, 1'b0);
        check("t3_drop",      32'(drop),     1);
        check("t3_head_port", 32'(out_port), 0);
        check("t3_head_data", 32'(out_data), 32'h2);
        tick();
        check("t3_drop_once", 32'(drop), 0);
        out_ready = 1'b1;
        tick();
        check("t3_second_data", 32'(out_data), 32'h5);
        tick();
        check("t3_drained", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Full FIFO with a pop on the frame_done cycle: no drop.
        send_frame(1, 4, 4, 32'h9, 1'b0, 1'b0);
        send_frame(2, 2, 2, 32'h3, 1'b0, 1'b0);
        send_frame(3, 3, 3, 32'h7, 1'b0, 1'b1);
        check("t4_no_drop",   32'(drop),     0);
        check("t4_head_port", 32'(out_port), 2);
        out_ready = 1'b1;
        tick();
        check("t4_last_data", 32'(out_data), 32'h7);
        check("t4_last_port", 32'(out_port), 3);
        tick();
        out_ready = 1'b0;

        // Overlong frame: 17 ones.
        send_frame(0, 15, 17, 32'h1FFFF, 1'b0, 1'b0);
        check("t5_data", 32'(out_data), 32'h7FFF);
        check("t5_len",  32'(out_len),  15);
        check("t5_err",  32'(out_err),  1);
        pop_one();

        // Zero-length frames.
        send_frame(2, 0, 0, 32'h0, 1'b0, 1'b0);
        check("t6_zero_len", 32'(out_len),  0);
        check("t6_zero_err", 32'(out_err),  0);
        check("t6_zero_prt", 32'(out_port), 2);
        pop_one();
        send_frame(1, 3, 0, 32'h0, 1'b0, 1'b0);
        check("t6_zero_err_mismatch", 32'(out_err), 1);
        pop_one();

        // Reset mid-frame, then a clean frame under gated clk_en.
        port_addr = 2'd3;
        data_len  = 4'd3;
        clk_en    = 1'b1;
        ser_valid = 1'b1;
        ser_bit   = 1'b1;
        tick();
        ser_bit = 1'b0;
        tick();
        ser_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("t7_reset_valid", 32'(out_valid), 0);
        check("t7_reset_drop",  32'(drop),      0);
        send_frame(1, 3, 3, 32'h5, 1'b1, 1'b0);
        check("t7_data", 32'(out_data), 32'h5);
        check("t7_len",  32'(out_len),  3);
        check("t7_err",  32'(out_err),  0);
        check("t7_port", 32'(out_port), 1);
        pop_one();
        check("t7_only_clean", 32'(out_valid), 0);

        // Randomized traffic with a random consumer.
        rand_ready = 1'b1;
        for (int f = 0; f < 60; f++) begin
            int          n;
            int          len;
            logic [31:0] pat;
            n   = $urandom_range(0, 18);
            pat = $urandom;
            len = ($urandom_range(0, 1) == 1 && n <= 15) ? n : $urandom_range(0, 15);
            send_frame($urandom_range(0, 3), len, n, pat, 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 2)) begin
                clk_en    = 1'($urandom_range(0, 1));
                ser_valid = 1'b0;
                tick();
            end
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (4) tick();
        check("final_empty", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
